// File: rtl/gray_to_binary_sync.sv
// gray_to_binary_sync
//   Receive side of a Gray-coded count that crosses into this clock domain.
//   The Gray word is passed through a plain flop synchroniser, decoded to
//   binary, and compared against the previous sample. Each sample produces a
//   change flag, a signed-modulo step (delta), and a step error flag when more
//   than one Gray bit moved at once. A saturating counter accumulates step
//   errors.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   gray_in     Gray-coded count, asynchronous to clk
//   binary_out  registered decoded binary value
//   valid       binary_out holds a decoded sample taken since reset
//   changed     1-cycle pulse: new sample differs from previous
//   delta       (new - previous) binary, modulo 2^WIDTH
//   step_err    1-cycle pulse: new sample differs from previous in >1 bit
//   err_count   saturating count of step_err pulses
module gray_to_binary_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] binary_out,
  output logic             valid,
  output logic             changed,
  output logic [WIDTH-1:0] delta,
  output logic             step_err,
  output logic [7:0]       err_count
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  // Synchroniser chain; index 0 is the first flop, SYNC_STAGES-1 the last.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;

  // Counts edges since reset until the last synchroniser stage holds a word
  // that was actually sampled from gray_in after reset. Until then the chain
  // only contains reset zeros, which must not be mistaken for a real sample
  // (doing so would report a bogus step against the first genuine value).
  logic [FILL_W-1:0] fill_reg;
  logic              chain_full;

  logic [WIDTH-1:0] prev_gray_reg;
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] s_dec;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign s_last     = sync_reg[SYNC_STAGES-1];
  assign s_dec      = gray_decode(s_last);
  assign diff       = s_last ^ prev_gray_reg;
  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign multi_bit  = (diff & (diff - WIDTH'(1))) != '0;
  assign chain_full = (fill_reg == FILL_W'(SYNC_STAGES));

  // No logic between synchroniser stages: a straight shift of the raw word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], gray_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_reg <= '0;
    end else if (!chain_full) begin
      fill_reg <= fill_reg + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      binary_out    <= '0;
      prev_gray_reg <= '0;
      valid         <= 1'b0;
      changed       <= 1'b0;
      delta         <= '0;
      step_err      <= 1'b0;
      err_count     <= '0;
    end else begin
      changed  <= 1'b0;
      step_err <= 1'b0;
      if (chain_full) begin
        binary_out    <= s_dec;
        prev_gray_reg <= s_last;
        valid         <= 1'b1;
        if (valid) begin
          changed  <= (diff != '0);
          step_err <= multi_bit;
          delta    <= s_dec - binary_out;
          if (multi_bit && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
          end
        end else begin
          // First sample only primes the comparison history.
          delta <= '0;
        end
      end
    end
  end

endmodule
